// File: rtl/result_serializer.sv
// Parallel-to-serial result framer: accepts a word over valid/ready into a one-entry
// holding buffer and shifts it out on one pin, framed by ser_frame, with a fixed idle gap.
module result_serializer #(
  parameter int unsigned WIDTH     = 16,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned GAP       = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_data,
  output logic             ser_frame,
  output logic             frame_done,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned GW = 4;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [GW-1:0] LAST_GAP = GW'((GAP == 0) ? 0 : GAP - 1);
  localparam bit HAS_GAP = (GAP != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAPST = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [WIDTH-1:0] pend, pend_n;
  logic             pend_valid, pend_valid_n;
  logic [CW-1:0]    bit_cnt, bit_cnt_n;
  logic [GW-1:0]    gap_cnt, gap_cnt_n;
  logic             ser_data_n, ser_frame_n, frame_done_n, busy_n;
  logic             accept;
  logic             load;

  assign in_ready = enable && !pend_valid && !reset;
  assign accept   = in_valid && in_ready;

  // State register; serial pins are flops so they never glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      ser_data   <= 1'b0;
      ser_frame  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      pend       <= pend_n;
      pend_valid <= pend_valid_n;
      bit_cnt    <= bit_cnt_n;
      gap_cnt    <= gap_cnt_n;
      ser_data   <= ser_data_n;
      ser_frame  <= ser_frame_n;
      frame_done <= frame_done_n;
      busy       <= busy_n;
    end
  end

  // Next-state logic; with enable low every register keeps its value.
  always_comb begin
    state_n      = state;
    shreg_n      = shreg;
    pend_n       = pend;
    pend_valid_n = pend_valid;
    bit_cnt_n    = bit_cnt;
    gap_cnt_n    = gap_cnt;
    load         = 1'b0;

    if (enable) begin
      if (accept) begin
        pend_n       = in_data;
        pend_valid_n = 1'b1;
      end

      case (state)
        IDLE: begin
          if (pend_valid) load = 1'b1;
        end
        SHIFT: begin
          if (bit_cnt == LAST_BIT) begin
            if (HAS_GAP) begin
              state_n   = GAPST;
              gap_cnt_n = '0;
            end else if (pend_valid) begin
              load = 1'b1;
            end else begin
              state_n = IDLE;
            end
          end else begin
            shreg_n   = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
            bit_cnt_n = bit_cnt + CW'(1);
          end
        end
        GAPST: begin
          if (gap_cnt == LAST_GAP) begin
            if (pend_valid) load = 1'b1;
            else            state_n = IDLE;
          end else begin
            gap_cnt_n = gap_cnt + GW'(1);
          end
        end
        default: state_n = IDLE;
      endcase

      // pend is full here, so accept cannot be set in the same cycle
      if (load) begin
        state_n      = SHIFT;
        shreg_n      = pend;
        pend_valid_n = 1'b0;
        bit_cnt_n    = '0;
      end
    end

    ser_frame_n  = (state_n == SHIFT);
    ser_data_n   = ser_frame_n && (MSB_FIRST ? shreg_n[WIDTH-1] : shreg_n[0]);
    frame_done_n = ser_frame_n && (bit_cnt_n == LAST_BIT);
    busy_n       = (state_n != IDLE) || pend_valid_n;
  end

endmodule

// File: tb/tb_result_serializer.sv
// Bench for result_serializer: directed scenarios plus randomized traffic against a
// word-queue reference model; a second instance covers LSB-first, gapless framing.
module tb_result_serializer;

  localparam int unsigned W     = 16;
  localparam int unsigned GAP_A = 1;

  logic         clk = 1'b0;
  logic         reset, enable, in_valid;
  logic [W-1:0] in_data;
  logic         in_ready, ser_data, ser_frame, frame_done, busy;

  logic         reset_b, enable_b, in_valid_b;
  logic [W-1:0] in_data_b;
  logic         in_ready_b, ser_data_b, ser_frame_b, frame_done_b, busy_b;

  always #5 clk = ~clk;

  result_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP(GAP_A)) dut (
    .clk(clk), .reset(reset), .enable(enable), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ser_data(ser_data), .ser_frame(ser_frame),
    .frame_done(frame_done), .busy(busy)
  );

  result_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .GAP(0)) dut_b (
    .clk(clk), .reset(reset_b), .enable(enable_b), .in_data(in_data_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .ser_data(ser_data_b), .ser_frame(ser_frame_b),
    .frame_done(frame_done_b), .busy(busy_b)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model: words accepted but not yet on the wire, and position in the current frame.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] cur = '0;
  int  idx = 0;
  bit  in_frame = 0;
  int  idle_run = 0;
  bit  have_prev = 0;
  bit  pend_at_end = 0;
  int  frames_done = 0;
  int  acc_count = 0;
  bit  last_acc = 0;
  logic m_frame = 0, m_data = 0, m_done = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: capture handshake before the edge, then check the serial stream after it.
  task automatic step();
    logic         acc, en_e, rst_e;
    logic [W-1:0] d;
    bit           started;
    #3;
    acc   = in_valid && in_ready;
    en_e  = enable;
    rst_e = reset;
    d     = in_data;
    @(posedge clk);
    #1;
    last_acc = acc;
    if (rst_e) begin
      exp_q.delete();
      in_frame = 0; have_prev = 0; pend_at_end = 0; idle_run = 0;
      m_frame = 0; m_data = 0; m_done = 0;
      chk("rst_frame", ser_frame, 0);
      chk("rst_data", ser_data, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", in_ready, 0);
      return;
    end
    if (acc) begin
      exp_q.push_back(d);
      acc_count++;
    end
    if (!en_e) begin
      chk("frz_frame", ser_frame, m_frame);
      chk("frz_data", ser_data, m_data);
      chk("frz_done", frame_done, m_done);
      return;
    end
    if (in_frame) begin
      idx++;
      if (idx == W) begin
        in_frame = 0;
        frames_done++;
        idle_run = 0;
        have_prev = 1;
        pend_at_end = (exp_q.size() > 0);
      end
    end
    started = 0;
    if (!in_frame) begin
      if (ser_frame === 1'b1) begin
        started = 1;
        chk("word_avail", exp_q.size() > 0, 1);
        cur = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        if (have_prev) chk("min_gap", idle_run >= int'(GAP_A), 1);
        if (pend_at_end) chk("exact_gap", idle_run, GAP_A);
        pend_at_end = 0;
        in_frame = 1;
        idx = 0;
      end else begin
        idle_run++;
      end
    end
    m_frame = in_frame;
    m_data  = in_frame ? cur[W-1-idx] : 1'b0;
    m_done  = in_frame && (idx == W - 1);
    if (!started) chk("frame", ser_frame, m_frame);
    chk("data", ser_data, m_data);
    chk("done", frame_done, m_done);
  endtask

  initial begin
    int f0, a0, ok;
    bit eb, ed;
    reset = 1; enable = 1; in_valid = 0; in_data = '0;
    reset_b = 1; enable_b = 1; in_valid_b = 0; in_data_b = '0;

    // Reset held three cycles, then released.
    repeat (3) step();
    reset = 0;
    #1;
    chk("t1_ready", in_ready, 1);
    chk("t1_busy", busy, 0);

    // Single word from idle.
    in_data = 16'hA5C3; in_valid = 1;
    step();
    in_valid = 0;
    chk("t2_busy_pend", busy, 1);
    chk("t2_ready_full", in_ready, 0);
    chk("t2_no_frame_yet", ser_frame, 0);
    step();
    chk("t2_first_frame", ser_frame, 1);
    chk("t2_first_bit", ser_data, 1);
    chk("t2_ready_empty", in_ready, 1);
    repeat (15) step();
    step();
    chk("t2_gap_busy", busy, 1);
    step();
    chk("t2_idle_busy", busy, 0);

    // Back-to-back words, second held valid while the buffer is full.
    in_data = 16'hFFFF; in_valid = 1;
    step();
    in_data = 16'h0001;
    chk("t3_ready_full", in_ready, 0);
    step();
    chk("t3_ready_after_reload", in_ready, 1);
    step();
    in_valid = 0;
    chk("t3_second_accepted", in_ready, 0);
    chk("t3_busy", busy, 1);
    repeat (14) step();
    step();
    chk("t3_gap_frame", ser_frame, 0);
    chk("t3_gap_busy", busy, 1);
    step();
    chk("t3_second_frame", ser_frame, 1);
    repeat (15) step();
    step();
    chk("t3_end_busy", busy, 1);
    step();
    chk("t3_busy_drop", busy, 0);

    // Enable low for three cycles mid-frame.
    f0 = frames_done;
    in_data = 16'h8001; in_valid = 1;
    step();
    in_valid = 0;
    repeat (5) step();
    enable = 0;
    repeat (3) begin
      step();
      chk("t4_ready_frozen", in_ready, 0);
      chk("t4_frame_frozen", ser_frame, 1);
    end
    enable = 1;
    repeat (11) step();
    step();
    chk("t4_frame_end", ser_frame, 0);
    step();
    chk("t4_frames", frames_done, f0 + 1);
    chk("t4_idle", busy, 0);

    // Reset mid-frame with a word pending.
    in_data = 16'h1234; in_valid = 1;
    step();
    in_data = 16'hBEEF;
    step();
    step();
    in_valid = 0;
    repeat (5) step();
    chk("t5_busy_before", busy, 1);
    reset = 1;
    step();
    reset = 0;
    #1;
    chk("t5_ready_rel", in_ready, 1);
    f0 = frames_done;
    in_data = 16'h00F0; in_valid = 1;
    step();
    in_valid = 0;
    repeat (16) step();
    repeat (4) step();
    chk("t5_frames", frames_done, f0 + 1);
    chk("t5_idle", busy, 0);

    // Randomized traffic with enable dropouts and idle-time data wiggle.
    f0 = frames_done;
    a0 = acc_count;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) begin
        in_data = W'($urandom);
        enable  = ($urandom_range(0, 5) != 0);
        step();
      end
      in_data  = W'($urandom);
      in_valid = 1;
      ok = 0;
      for (int t = 0; t < 200 && ok == 0; t++) begin
        enable = ($urandom_range(0, 5) != 0);
        step();
        if (last_acc) ok = 1;
      end
      in_valid = 0;
      chk("rnd_accept", ok, 1);
    end
    enable = 1;
    repeat (60) step();
    chk("rnd_frames", frames_done - f0, acc_count - a0);
    chk("rnd_queue_empty", exp_q.size(), 0);
    chk("rnd_idle", busy, 0);

    // LSB-first, gapless instance.
    reset_b = 0;
    step();
    chk("t6_ready", in_ready_b, 1);
    chk("t6_busy", busy_b, 0);
    in_data_b = 16'h0001; in_valid_b = 1;
    step();
    chk("t6_no_frame_yet", ser_frame_b, 0);
    in_data_b = 16'h8000;
    for (int k = 0; k < 32; k++) begin
      step();
      if (k == 0) chk("t6_ready_reload", in_ready_b, 1);
      if (k == 1) in_valid_b = 0;
      eb = (k == 0) || (k == 31);
      ed = (k == 15) || (k == 31);
      chk("t6_frame", ser_frame_b, 1);
      chk("t6_data", ser_data_b, eb);
      chk("t6_done", frame_done_b, ed);
    end
    step();
    chk("t6_end_frame", ser_frame_b, 0);
    chk("t6_end_data", ser_data_b, 0);
    chk("t6_end_busy", busy_b, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
